checkpoint_ras: RTL

CHECKPOINT_RAS -- requirements
Module: checkpoint_ras

---
 rtl/checkpoint_ras.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/checkpoint_ras.sv
// checkpoint_ras: circular return-address stack with speculative checkpoints.
// Each checkpoint slot holds {tail, count, top value}; a restore reloads the
// pointers and rewrites only the top entry, which is all a mispredict repair
// needs for a RAS.
module checkpoint_ras #(
   parameter int DEPTH      = 8,
   parameter int PC_W       = 32,
   parameter int NUM_CKPT   = 4,
   parameter int RET_OFFSET = 4,
   localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
   localparam int TW = $clog2(DEPTH),
   localparam int NW = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push_en,
   input  logic            pop_en,
   input  logic [PC_W-1:0] push_pc,
   input  logic            flush,
   input  logic            ckpt_save,
   input  logic            ckpt_restore,
   input  logic [CW-1:0]   ckpt_restore_tag,
   input  logic            ckpt_free,
   input  logic [CW-1:0]   ckpt_free_tag,
   output logic [PC_W-1:0] top_pc,
   output logic            valid_out,
   output logic [NW-1:0]   count_out,
   output logic            ckpt_avail,
   output logic [CW-1:0]   ckpt_tag
);

   localparam logic [TW-1:0] T_ONE = TW'(1);
   localparam logic [NW-1:0] N_ONE = NW'(1);
   localparam logic [NW-1:0] FULL  = NW'(DEPTH);

   typedef struct packed {
      logic [TW-1:0]   tail;
      logic [NW-1:0]   cnt;
      logic [PC_W-1:0] top;
   } snap_t;

   logic [PC_W-1:0]     stack [DEPTH];
   logic [TW-1:0]       tail;
   logic [NW-1:0]       count;
   snap_t               snap  [NUM_CKPT];
   logic [NUM_CKPT-1:0] alloc;

   // push/pop next-state candidates
   logic [PC_W-1:0] ret;
   logic            wr_en;
   logic [TW-1:0]   wr_idx;
   logic [TW-1:0]   tail_pp;
   logic [NW-1:0]   cnt_pp;
   logic [PC_W-1:0] top_pp;

   // restore / checkpoint bookkeeping
   snap_t               rs;
   logic                rs_hit;
   logic                save_ok;
   logic [CW-1:0]       free_idx;
   logic [NUM_CKPT-1:0] alloc_n;

   assign top_pc     = stack[tail - T_ONE];
   assign valid_out  = (count != '0);
   assign count_out  = count;
   assign ckpt_avail = ~&alloc;
   assign ckpt_tag   = free_idx;

   // lowest-index free checkpoint slot
   always_comb begin
      free_idx = '0;
      for (int i = NUM_CKPT - 1; i >= 0; i--)
         if (!alloc[i]) free_idx = CW'(i);
   end

   // push/pop effect; top_pp is the top value of the resulting state, needed
   // so a same-cycle save captures post-push/pop contents
   always_comb begin
      ret     = push_pc + PC_W'(RET_OFFSET);
      wr_en   = 1'b0;
      wr_idx  = tail;
      tail_pp = tail;
      cnt_pp  = count;
      if (push_en && (!pop_en || count == '0)) begin
         wr_en   = 1'b1;
         tail_pp = tail + T_ONE;
         cnt_pp  = (count == FULL) ? FULL : count + N_ONE;
      end else if (push_en) begin
         // push+pop on a live stack replaces the top in place
         wr_en  = 1'b1;
         wr_idx = tail - T_ONE;
      end else if (pop_en && count != '0) begin
         tail_pp = tail - T_ONE;
         cnt_pp  = count - N_ONE;
      end
      top_pp = wr_en ? ret : stack[tail_pp - T_ONE];
   end

   // select the snapshot addressed by the restore tag; unallocated tags miss
   always_comb begin
      rs     = '0;
      rs_hit = 1'b0;
      for (int i = 0; i < NUM_CKPT; i++)
         if (ckpt_restore_tag == CW'(i)) begin
            rs     = snap[i];
            rs_hit = ckpt_restore && alloc[i];
         end
   end

   assign save_ok = ckpt_save && ckpt_avail && !flush && !rs_hit;

   // allocation update: free first so a save never loses to a same-tag free
   always_comb begin
      alloc_n = alloc;
      for (int i = 0; i < NUM_CKPT; i++) begin
         if (ckpt_free && ckpt_free_tag == CW'(i)) alloc_n[i] = 1'b0;
         if (rs_hit && ckpt_restore_tag == CW'(i)) alloc_n[i] = 1'b0;
         if (save_ok && free_idx == CW'(i))        alloc_n[i] = 1'b1;
      end
      if (flush) alloc_n = '0;
   end

   // state update in priority order: reset, flush, restore, push/pop+save
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
         for (int i = 0; i < NUM_CKPT; i++) snap[i] <= '0;
         tail  <= '0;
         count <= '0;
         alloc <= '0;
      end else begin
         alloc <= alloc_n;
         if (flush) begin
            tail  <= '0;
            count <= '0;
         end else if (rs_hit) begin
            tail  <= rs.tail;
            count <= rs.cnt;
            if (rs.cnt != '0) stack[rs.tail - T_ONE] <= rs.top;
         end else begin
            tail  <= tail_pp;
            count <= cnt_pp;
            if (wr_en) stack[wr_idx] <= ret;
            for (int i = 0; i < NUM_CKPT; i++)
               if (save_ok && free_idx == CW'(i))
                  snap[i] <= '{tail: tail_pp, cnt: cnt_pp, top: top_pp};
         end
      end
   end

endmodule
